// File: rtl/mem_access_stage_pkg.sv
// Shared widths, flag encodings, FSM state codes and decode helpers for the
// memory-access stage and its data-alignment logic.
package mem_access_stage_pkg;

  localparam int XLEN           = 32;
  localparam int XREG_ADDRWIDTH = 5;

  localparam logic [XLEN-1:0] ZERO_32BIT = '0;

  localparam logic [4:0] NO_LOAD = 5'b00000;
  localparam logic [4:0] LOAD_B  = 5'b00001;
  localparam logic [4:0] LOAD_H  = 5'b00010;
  localparam logic [4:0] LOAD_W  = 5'b00100;
  localparam logic [4:0] LOAD_BU = 5'b01000;
  localparam logic [4:0] LOAD_HU = 5'b10000;

  localparam logic [2:0] NO_STORE = 3'b000;
  localparam logic [2:0] STORE_B  = 3'b001;
  localparam logic [2:0] STORE_H  = 3'b010;
  localparam logic [2:0] STORE_W  = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_kind_e;

  // Instruction record held while a memory transaction is in flight.
  typedef struct packed {
    logic [XLEN-1:0]           addr;
    logic [XLEN-1:0]           sdata;
    logic [XREG_ADDRWIDTH-1:0] rd_addr;
    logic [4:0]                load_flag;
    logic [2:0]                store_flag;
    logic                      is_load;
  } mem_rec_t;

  // A nonzero load flag always wins; an unknown load code is a plain ALU op.
  function automatic op_kind_e decode_op(input logic [4:0] lf, input logic [2:0] sf);
    op_kind_e kind;
    kind = OP_ALU;
    if (lf != NO_LOAD) begin
      if (lf inside {LOAD_B, LOAD_H, LOAD_W, LOAD_BU, LOAD_HU}) begin
        kind = OP_LOAD;
      end
    end else if (sf inside {STORE_B, STORE_H, STORE_W}) begin
      kind = OP_STORE;
    end
    return kind;
  endfunction

  function automatic logic is_misaligned(input logic [4:0] lf, input logic [2:0] sf,
                                         input logic [1:0] addr_lo);
    op_kind_e kind;
    logic     half_acc;
    logic     word_acc;
    kind     = decode_op(lf, sf);
    half_acc = ((kind == OP_LOAD) && (lf inside {LOAD_H, LOAD_HU})) ||
               ((kind == OP_STORE) && (sf == STORE_H));
    word_acc = ((kind == OP_LOAD) && (lf == LOAD_W)) ||
               ((kind == OP_STORE) && (sf == STORE_W));
    return (half_acc && addr_lo[0]) || (word_acc && (addr_lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] sf, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (sf)
      STORE_B: strb = 4'b0001 << addr_lo;
      STORE_H: strb = 4'b0011 << addr_lo;
      STORE_W: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] sf, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] wd;
    case (sf)
      STORE_B: wd = {4{d[7:0]}};
      STORE_H: wd = {2{d[15:0]}};
      STORE_W: wd = d;
      default: wd = ZERO_32BIT;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data
// memory (slave): req/gnt request phase followed by rvalid read data.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [3:0]      dmem_wstrb_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wstrb_o,
    output dmem_wdata_o,
    input  dmem_gnt_i,
    input  dmem_rvalid_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wstrb_o,
    input  dmem_wdata_o,
    output dmem_gnt_i,
    output dmem_rvalid_i,
    output dmem_rdata_i
  );

endinterface

// File: rtl/load_data_align.sv
// Selects the addressed byte/half/word out of a read word and sign- or
// zero-extends it according to the load kind. Purely combinational.
module load_data_align
  import mem_access_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [4:0]      load_flag_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign byte_lane[gi] = rdata_i[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
    assign half_lane[gi] = rdata_i[16*gi +: 16];
  end

  assign byte_sel = byte_lane[addr_lo_i];
  assign half_sel = half_lane[addr_lo_i[1]];

  always_comb begin
    case (load_flag_i)
      LOAD_B:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LOAD_BU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_H:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LOAD_HU: data_o = {{(XLEN-16){1'b0}}, half_sel};
      LOAD_W:  data_o = rdata_i;
      default: data_o = ZERO_32BIT;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues the data-memory transaction for an
// ALU-computed address, aligns load data and emits one writeback per instruction.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           alu_result_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  input  logic [4:0]                load_flag_in,
  input  logic [2:0]                store_flag_in,
  input  logic [XLEN-1:0]           store_data_in,

  mem_access_stage_if.master        dmem,

  output logic                      wb_valid_o,
  output logic                      wb_en_o,
  output logic [XREG_ADDRWIDTH-1:0] wb_addr_o,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      misalign_o,
  output logic [XLEN-1:0]           misalign_addr_o
);

  logic [1:0]                state_q, state_d;
  mem_rec_t                  rec_q, rec_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      wb_en_q, wb_en_d;
  logic [XREG_ADDRWIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]           wb_data_q, wb_data_d;
  logic                      misalign_q, misalign_d;
  logic [XLEN-1:0]           misalign_addr_q, misalign_addr_d;

  op_kind_e                  acc_kind;
  logic                      acc_misalign;
  logic                      accept;
  logic                      in_req;
  logic [XLEN-1:0]           load_data;

  assign in_ready     = (state_q == ST_IDLE);
  assign accept       = in_valid && in_ready;
  assign acc_kind     = decode_op(load_flag_in, store_flag_in);
  assign acc_misalign = is_misaligned(load_flag_in, store_flag_in, alu_result_in[1:0]);
  assign in_req       = (state_q == ST_REQ);

  load_data_align u_load_data_align (
    .rdata_i     (dmem.dmem_rdata_i),
    .addr_lo_i   (rec_q.addr[1:0]),
    .load_flag_i (rec_q.load_flag),
    .data_o      (load_data)
  );

  always_comb begin
    state_d         = state_q;
    rec_d           = rec_q;
    wb_valid_d      = 1'b0;
    wb_en_d         = 1'b0;
    wb_addr_d       = '0;
    wb_data_d       = ZERO_32BIT;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rec_d.addr       = alu_result_in;
          rec_d.sdata      = store_data_in;
          rec_d.rd_addr    = rd_addr_in;
          rec_d.load_flag  = load_flag_in;
          rec_d.is_load    = (acc_kind == OP_LOAD);
          // Loads never drive strobes, even when a store code rides along.
          rec_d.store_flag = (acc_kind == OP_STORE) ? store_flag_in : NO_STORE;

          if (acc_kind == OP_ALU) begin
            wb_valid_d = 1'b1;
            wb_en_d    = rd_en_in && (rd_addr_in != '0);
            wb_addr_d  = rd_addr_in;
            wb_data_d  = alu_result_in;
          end else if (acc_misalign) begin
            wb_valid_d      = 1'b1;
            wb_addr_d       = rd_addr_in;
            misalign_d      = 1'b1;
            misalign_addr_d = alu_result_in;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (dmem.dmem_gnt_i) begin
          if (rec_q.is_load) begin
            state_d = ST_WAIT;
          end else begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_addr_d  = rec_q.rd_addr;
          end
        end
      end

      ST_WAIT: begin
        if (dmem.dmem_rvalid_i) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_en_d    = (rec_q.rd_addr != '0);
          wb_addr_d  = rec_q.rd_addr;
          wb_data_d  = load_data;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rec_q           <= '0;
      wb_valid_q      <= 1'b0;
      wb_en_q         <= 1'b0;
      wb_addr_q       <= '0;
      wb_data_q       <= ZERO_32BIT;
      misalign_q      <= 1'b0;
      misalign_addr_q <= ZERO_32BIT;
    end else begin
      state_q         <= state_d;
      rec_q           <= rec_d;
      wb_valid_q      <= wb_valid_d;
      wb_en_q         <= wb_en_d;
      wb_addr_q       <= wb_addr_d;
      wb_data_q       <= wb_data_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Bus fields come straight from the held record, so they stay stable until gnt.
  assign dmem.dmem_req_o   = in_req;
  assign dmem.dmem_we_o    = in_req && !rec_q.is_load;
  assign dmem.dmem_addr_o  = in_req ? {rec_q.addr[XLEN-1:2], 2'b00} : ZERO_32BIT;
  assign dmem.dmem_wstrb_o = in_req ? store_strobe(rec_q.store_flag, rec_q.addr[1:0]) : 4'b0000;
  assign dmem.dmem_wdata_o = in_req ? store_wdata(rec_q.store_flag, rec_q.sdata) : ZERO_32BIT;

  assign wb_valid_o      = wb_valid_q;
  assign wb_en_o         = wb_en_q;
  assign wb_addr_o       = wb_addr_q;
  assign wb_data_o       = wb_data_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a random
// instruction mix checked against a transaction-level reference model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result_in;
  logic        rd_en_in;
  logic [4:0]  rd_addr_in;
  logic [4:0]  load_flag_in;
  logic [2:0]  store_flag_in;
  logic [31:0] store_data_in;
  logic        wb_valid_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if dmem_if ();

  mem_access_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_result_in   (alu_result_in),
    .rd_en_in        (rd_en_in),
    .rd_addr_in      (rd_addr_in),
    .load_flag_in    (load_flag_in),
    .store_flag_in   (store_flag_in),
    .store_data_in   (store_data_in),
    .dmem            (dmem_if),
    .wb_valid_o      (wb_valid_o),
    .wb_en_o         (wb_en_o),
    .wb_addr_o       (wb_addr_o),
    .wb_data_o       (wb_data_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [4:0] lf, input logic [2:0] sf);
    if (lf != 5'b00000) begin
      if (lf == 5'b00001 || lf == 5'b01000) return 1;
      if (lf == 5'b00010 || lf == 5'b10000) return 2;
      if (lf == 5'b00100) return 4;
      return 0;
    end
    if (sf == 3'b001) return 1;
    if (sf == 3'b010) return 2;
    if (sf == 3'b100) return 4;
    return 0;
  endfunction

  function automatic bit ref_is_load(input logic [4:0] lf);
    return lf inside {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [4:0] lf);
    int          sz;
    logic [31:0] v;
    logic [31:0] mask;
    sz = ref_size(lf, 3'b000);
    if (sz == 4) return rdata;
    v    = rdata >> (8 * (addr % 4));
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = v & mask;
    if ((lf == 5'b00001 || lf == 5'b00010) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] sf, input logic [31:0] addr);
    int         sz;
    int         off;
    logic [3:0] s;
    sz  = ref_size(5'b00000, sf);
    off = addr % 4;
    s   = 4'b0000;
    for (int b = 0; b < 4; b++) s[b] = (sz > 0) && (b >= off) && (b < off + sz);
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] sf, input logic [31:0] d);
    int          sz;
    logic [31:0] w;
    sz = ref_size(5'b00000, sf);
    w  = 32'h0;
    if (sz > 0) for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % sz) +: 8];
    return w;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic do_op(input logic [4:0] lf, input logic [2:0] sf, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic rd_en, input logic [4:0] rd,
                       input int gd, input int rvd, input logic [31:0] rdata, input bit junk_rv,
                       output logic ready0, output logic saw_req, output logic req_we,
                       output logic [31:0] req_addr, output logic [3:0] req_wstrb,
                       output logic [31:0] req_wdata, output bit held, output bit early_wb,
                       output logic wb_v, output logic wb_e, output logic [4:0] wb_a,
                       output logic [31:0] wb_d, output logic mis, output logic [31:0] mis_a);
    in_valid      = 1'b1;
    load_flag_in  = lf;
    store_flag_in = sf;
    alu_result_in = addr;
    store_data_in = sdata;
    rd_en_in      = rd_en;
    rd_addr_in    = rd;
    ready0        = in_ready;
    @(negedge clk);
    in_valid  = 1'b0;
    saw_req   = dmem_if.dmem_req_o;
    req_we    = dmem_if.dmem_we_o;
    req_addr  = dmem_if.dmem_addr_o;
    req_wstrb = dmem_if.dmem_wstrb_o;
    req_wdata = dmem_if.dmem_wdata_o;
    held      = 1'b1;
    early_wb  = 1'b0;
    if (saw_req === 1'b1) begin
      for (int k = 0; k <= gd; k++) begin
        if (dmem_if.dmem_req_o !== 1'b1 || dmem_if.dmem_addr_o !== req_addr ||
            dmem_if.dmem_wstrb_o !== req_wstrb || dmem_if.dmem_wdata_o !== req_wdata ||
            dmem_if.dmem_we_o !== req_we || in_ready !== 1'b0) held = 1'b0;
        if (wb_valid_o !== 1'b0) early_wb = 1'b1;
        if (k == gd) begin
          dmem_if.dmem_gnt_i    = 1'b1;
          dmem_if.dmem_rvalid_i = junk_rv;
          dmem_if.dmem_rdata_i  = $urandom;
        end
        @(negedge clk);
      end
      dmem_if.dmem_gnt_i    = 1'b0;
      dmem_if.dmem_rvalid_i = 1'b0;
      if (req_we === 1'b0) begin
        for (int k = 0; k <= rvd; k++) begin
          if (dmem_if.dmem_req_o !== 1'b0 || in_ready !== 1'b0) held = 1'b0;
          if (wb_valid_o !== 1'b0) early_wb = 1'b1;
          if (k == rvd) begin
            dmem_if.dmem_rvalid_i = 1'b1;
            dmem_if.dmem_rdata_i  = rdata;
          end
          @(negedge clk);
        end
        dmem_if.dmem_rvalid_i = 1'b0;
        dmem_if.dmem_rdata_i  = $urandom;
      end
    end
    wb_v  = wb_valid_o;
    wb_e  = wb_en_o;
    wb_a  = wb_addr_o;
    wb_d  = wb_data_o;
    mis   = misalign_o;
    mis_a = misalign_addr_o;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
    checks++; if (dmem_if.dmem_req_o !== 1'b0 || dmem_if.dmem_addr_o !== 32'h0 || dmem_if.dmem_wstrb_o !== 4'h0) begin
      errors++; $display("FAIL rst_bus req %b addr %h strb %h want 0", dmem_if.dmem_req_o, dmem_if.dmem_addr_o, dmem_if.dmem_wstrb_o); end
    checks++; if (wb_valid_o !== 1'b0 || wb_data_o !== 32'h0 || misalign_o !== 1'b0 || misalign_addr_o !== 32'h0) begin
      errors++; $display("FAIL rst_wb valid %b data %h mis %b maddr %h want 0", wb_valid_o, wb_data_o, misalign_o, misalign_addr_o); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: ready=%b req=%b wb_valid=%b", in_ready, dmem_if.dmem_req_o, wb_valid_o);
  endtask

  task automatic test_alu_back_to_back;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        en;
    for (int i = 0; i < 11; i++) begin
      d  = (i < 3) ? 32'h0000_1234 : $urandom;
      rd = (i < 3) ? 5'd5 : 5'($urandom_range(0, 31));
      en = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = 1'b1; alu_result_in = d; rd_addr_in = rd; rd_en_in = en;
      load_flag_in = 5'b00000; store_flag_in = 3'b000; store_data_in = $urandom;
      @(negedge clk);
      checks++; if (wb_valid_o !== 1'b1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL alu_b2b_valid op %0d valid %b ready %b want 1 1", i, wb_valid_o, in_ready); end
      checks++; if (wb_data_o !== d || wb_addr_o !== rd || wb_en_o !== (en && rd != 0)) begin
        errors++; $display("FAIL alu_b2b_rec op %0d got %h/%0d/%b want %h/%0d/%b", i, wb_data_o, wb_addr_o, wb_en_o, d, rd, en && rd != 0); end
      checks++; if (dmem_if.dmem_req_o !== 1'b0) begin errors++; $display("FAIL alu_no_req got %b want 0", dmem_if.dmem_req_o); end
      $display("alu op %0d: data=%h rd=%0d en=%b", i, wb_data_o, wb_addr_o, wb_en_o);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL alu_idle_valid got %b want 0", wb_valid_o); end
  endtask

  task automatic test_load_byte;
    logic r0, sr, we, wv, we2, ms; logic [31:0] ra, wd, wdd, ma; logic [3:0] ws; logic [4:0] wa; bit hd, ew;
    logic [4:0] kinds [2];
    logic [31:0] want [2];
    kinds[0] = LOAD_B;  want[0] = 32'hFFFF_FF80;
    kinds[1] = LOAD_BU; want[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      do_op(kinds[i], 3'b000, 32'h103, 32'h0, 1'b1, 5'd9, 0, 0, 32'h80FF_0000, 1'b0,
            r0, sr, we, ra, ws, wd, hd, ew, wv, we2, wa, wdd, ms, ma);
      checks++; if (sr !== 1'b1 || ra !== 32'h100 || we !== 1'b0 || ws !== 4'h0) begin
        errors++; $display("FAIL ldb_req req %b addr %h we %b strb %h want 1 100 0 0", sr, ra, we, ws); end
      checks++; if (wv !== 1'b1 || ew || !hd) begin errors++; $display("FAIL ldb_latency valid %b early %b proto %b want 1 0 1", wv, ew, hd); end
      checks++; if (wdd !== want[i] || we2 !== 1'b1 || wa !== 5'd9) begin
        errors++; $display("FAIL ldb_data got %h/%b/%0d want %h/1/9", wdd, we2, wa, want[i]); end
      $display("load byte kind %b: wb_data=%h", kinds[i], wdd);
    end
  endtask

  task automatic test_store_held;
    logic r0, sr, we, wv, we2, ms; logic [31:0] ra, wd, wdd, ma; logic [3:0] ws; logic [4:0] wa; bit hd, ew;
    do_op(5'b00000, STORE_H, 32'h202, 32'hDEAD_BEEF, 1'b1, 5'd3, 3, 0, 32'h0, 1'b0,
          r0, sr, we, ra, ws, wd, hd, ew, wv, we2, wa, wdd, ms, ma);
    checks++; if (sr !== 1'b1 || we !== 1'b1 || ra !== 32'h200) begin
      errors++; $display("FAIL sh_req req %b we %b addr %h want 1 1 200", sr, we, ra); end
    checks++; if (ws !== 4'b1100 || wd !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL sh_lanes strb %b data %h want 1100 beefbeef", ws, wd); end
    checks++; if (!hd || ew) begin errors++; $display("FAIL sh_held stable %b early %b want 1 0", hd, ew); end
    checks++; if (wv !== 1'b1 || we2 !== 1'b0) begin errors++; $display("FAIL sh_wb valid %b en %b want 1 0", wv, we2); end
    $display("store half: addr=%h strb=%b wdata=%h wb_en=%b", ra, ws, wd, we2);
  endtask

  task automatic test_misalign;
    logic r0, sr, we, wv, we2, ms; logic [31:0] ra, wd, wdd, ma; logic [3:0] ws; logic [4:0] wa; bit hd, ew;
    do_op(LOAD_W, 3'b000, 32'h106, 32'h0, 1'b1, 5'd4, 0, 0, 32'h0, 1'b0,
          r0, sr, we, ra, ws, wd, hd, ew, wv, we2, wa, wdd, ms, ma);
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL mis_req got %b want 0", sr); end
    checks++; if (wv !== 1'b1 || we2 !== 1'b0 || ms !== 1'b1 || ma !== 32'h106) begin
      errors++; $display("FAIL mis_pulse valid %b en %b mis %b addr %h want 1 0 1 106", wv, we2, ms, ma); end
    @(negedge clk);
    checks++; if (misalign_o !== 1'b0 || misalign_addr_o !== 32'h106 || wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL mis_hold mis %b addr %h valid %b want 0 106 0", misalign_o, misalign_addr_o, wb_valid_o); end
    $display("misalign: addr=%h", misalign_addr_o);
  endtask

  task automatic test_load_x0;
    logic r0, sr, we, wv, we2, ms; logic [31:0] ra, wd, wdd, ma; logic [3:0] ws; logic [4:0] wa; bit hd, ew;
    do_op(LOAD_W, 3'b000, 32'h400, 32'h0, 1'b1, 5'd0, 1, 2, 32'h1234_5678, 1'b1,
          r0, sr, we, ra, ws, wd, hd, ew, wv, we2, wa, wdd, ms, ma);
    checks++; if (wv !== 1'b1 || we2 !== 1'b0 || wdd !== 32'h1234_5678) begin
      errors++; $display("FAIL ldx0 valid %b en %b data %h want 1 0 12345678", wv, we2, wdd); end
    checks++; if (!hd || ew) begin errors++; $display("FAIL ldx0_proto stable %b early %b want 1 0", hd, ew); end
    $display("load x0: wb_en=%b data=%h", we2, wdd);
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; load_flag_in = LOAD_W; store_flag_in = 3'b000;
    alu_result_in = 32'h300; rd_addr_in = 5'd7; rd_en_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (dmem_if.dmem_req_o !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", dmem_if.dmem_req_o); end
    dmem_if.dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_if.dmem_gnt_i = 1'b0;
    checks++; if (dmem_if.dmem_req_o !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_wait req %b ready %b want 0 0", dmem_if.dmem_req_o, in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || dmem_if.dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0 || misalign_addr_o !== 32'h0) begin
      errors++; $display("FAIL rmid_rst ready %b req %b valid %b maddr %h want 1 0 0 0", in_ready, dmem_if.dmem_req_o, wb_valid_o, misalign_addr_o); end
    dmem_if.dmem_rvalid_i = 1'b1;
    dmem_if.dmem_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_if.dmem_rvalid_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_late_rvalid valid %b ready %b want 0 1", wb_valid_o, in_ready); end
    $display("reset mid-load: ready=%b wb_valid=%b", in_ready, wb_valid_o);
  endtask

  task automatic test_random_mix;
    logic r0, sr, we, wv, we2, ms; logic [31:0] ra, wd, wdd, ma; logic [3:0] ws; logic [4:0] wa; bit hd, ew;
    logic [4:0] loads [5];
    logic [2:0] stores [3];
    logic [4:0] lf; logic [2:0] sf; logic [31:0] addr, sdata, rdata; logic [4:0] rd; logic en;
    int sz; bit exp_mem, exp_mis, is_ld; logic exp_en;
    loads[0] = 5'b00001; loads[1] = 5'b00010; loads[2] = 5'b00100; loads[3] = 5'b01000; loads[4] = 5'b10000;
    stores[0] = 3'b001; stores[1] = 3'b010; stores[2] = 3'b100;
    for (int i = 0; i < 60; i++) begin
      lf = 5'b00000; sf = 3'b000;
      case ($urandom_range(0, 2))
        0: ;
        1: begin lf = loads[$urandom_range(0, 4)]; if ($urandom_range(0, 1) == 1) sf = stores[$urandom_range(0, 2)]; end
        default: sf = stores[$urandom_range(0, 2)];
      endcase
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      sdata = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31)); en = 1'($urandom_range(0, 1));
      sz      = ref_size(lf, sf);
      is_ld   = ref_is_load(lf);
      exp_mem = (sz > 0) && (addr % sz == 0);
      exp_mis = (sz > 0) && (addr % sz != 0);
      exp_en  = (sz == 0) ? (en && rd != 0) : (exp_mem && is_ld && rd != 0);
      do_op(lf, sf, addr, sdata, en, rd, $urandom_range(0, 3), $urandom_range(0, 3), rdata,
            1'($urandom_range(0, 1)), r0, sr, we, ra, ws, wd, hd, ew, wv, we2, wa, wdd, ms, ma);
      checks++; if (r0 !== 1'b1 || sr !== exp_mem) begin
        errors++; $display("FAIL rnd_issue op %0d ready %b req %b want 1 %b", i, r0, sr, exp_mem); end
      checks++; if (wv !== 1'b1 || we2 !== exp_en || ms !== exp_mis) begin
        errors++; $display("FAIL rnd_wb op %0d valid %b en %b mis %b want 1 %b %b", i, wv, we2, ms, exp_en, exp_mis); end
      if (exp_mem) begin
        checks++; if (ra !== {addr[31:2], 2'b00} || we !== !is_ld || ws !== (is_ld ? 4'h0 : ref_wstrb(sf, addr)) ||
                      (!is_ld && wd !== ref_wdata(sf, sdata)) || !hd || ew) begin
          errors++; $display("FAIL rnd_bus op %0d addr %h we %b strb %b wdata %h proto %b early %b", i, ra, we, ws, wd, hd, ew); end
      end
      if (exp_mis) begin
        checks++; if (ma !== addr) begin errors++; $display("FAIL rnd_maddr op %0d got %h want %h", i, ma, addr); end
      end
      if (sz == 0 || (exp_mem && is_ld)) begin
        checks++; if (wdd !== ((sz == 0) ? addr : ref_load(rdata, addr, lf)) || wa !== rd) begin
          errors++; $display("FAIL rnd_data op %0d got %h/%0d want %h/%0d", i, wdd, wa,
                             (sz == 0) ? addr : ref_load(rdata, addr, lf), rd); end
      end
      $display("rnd op %0d lf=%b sf=%b addr=%h wb_en=%b wb_data=%h mis=%b", i, lf, sf, addr, we2, wdd, ms);
    end
  endtask

  initial begin
    in_valid = 1'b0; alu_result_in = 32'h0; rd_en_in = 1'b0; rd_addr_in = 5'd0;
    load_flag_in = 5'b00000; store_flag_in = 3'b000; store_data_in = 32'h0;
    dmem_if.dmem_gnt_i = 1'b0; dmem_if.dmem_rvalid_i = 1'b0; dmem_if.dmem_rdata_i = 32'h0;
    test_reset();
    test_alu_back_to_back();
    test_load_byte();
    test_store_held();
    test_misalign();
    test_load_x0();
    test_reset_mid();
    test_random_mix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the ALU result (effective address or arithmetic result), rd enable/address, load/store flags and store data.
- Performs the data-memory transaction over a req/gnt/rvalid handshake, aligns and extends load data, and presents one registered writeback record per instruction.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width.
- XREG_ADDRWIDTH, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream record valid
- in_ready  out  1  stage can accept a record
- alu_result_in  in  XLEN  ALU result / effective address
- rd_en_in  in  1  writeback enable
- rd_addr_in  in  XREG_ADDRWIDTH  destination register
- load_flag_in  in  5  load kind
- store_flag_in  in  3  store kind
- store_data_in  in  XLEN  rs2 value for stores
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1=write
- dmem_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb_o  out  4  byte strobes
- dmem_wdata_o  out  XLEN  write data, lane-replicated
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  XLEN  read data
- wb_valid_o  out  1  one-cycle pulse: instruction retired by this stage
- wb_en_o  out  1  write register file
- wb_addr_o  out  XREG_ADDRWIDTH  destination
- wb_data_o  out  XLEN  writeback data
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- misalign_addr_o  out  XLEN  offending address, held until next misalign

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Flag encodings:
  - Loads: NO_LOAD=00000, LOAD_B=00001, LOAD_H=00010, LOAD_W=00100, LOAD_BU=01000, LOAD_HU=10000.
  - Stores: NO_STORE=000, STORE_B=001, STORE_H=010, STORE_W=100.
  - Any other value = non-memory op.
  - Load nonzero takes priority over store.
- States: IDLE, REQ, WAIT. in_ready = (state==IDLE).
- Accept: in_valid&&in_ready at the edge ending cycle T; inputs are captured.
  - Non-memory op: during T+1, wb_valid=1, wb_data=alu_result_in, wb_en=rd_en_in&&(rd_addr!=0). Stays IDLE, so back-to-back at 1/cycle.
  - Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0): no memory request. During T+1, wb_valid=1, wb_en=0, misalign_o=1, misalign_addr_o=addr. Stays IDLE.
  - Aligned load/store: go to REQ.
- REQ:
  - dmem_req_o=1; addr/we/wstrb/wdata stable until gnt.
  - On gnt, store: next cycle wb_valid=1, wb_en=0; state goes to IDLE.
  - On gnt, load: state goes to WAIT.
- WAIT:
  - dmem_req_o=0. rvalid is ignored in the gnt cycle itself.
  - On rvalid: next cycle wb_valid=1, wb_en=(rd_addr!=0), wb_data=aligned load data; state goes to IDLE.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{d[15:0]}}.
  - SW: wstrb=1111, wdata=d.
  - Loads: wstrb=0000.
- Load align:
  - Byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- Minimum latency (from accept in T):
  - Non-memory: wb_valid in T+1.
  - Store: gnt in T+1 gives wb_valid in T+2.
  - Load: gnt T+1, rvalid T+2 gives wb_valid in T+3.
- Outputs are zero when idle: dmem_req/we/wstrb/addr/wdata are 0 outside REQ; wb_valid and misalign_o are 0 except in their pulse cycle.
- Reset (any state, including mid-transaction):
  - All outputs 0 next cycle, state IDLE, in_ready=1.
  - A late rvalid after reset is ignored because it arrives in IDLE.
- in_valid while not ready: the record is not captured; upstream must hold it.

Decomposition:
- Shared config/package: XLEN, XREG_ADDRWIDTH, LOAD_*/STORE_* encodings, state encodings, ZERO_32BIT.
- One combinational sub-module, load_data_align (rdata, addr[1:0], load_flag -> extended data), reused by a future cache path.

Test Plan:
- ADD result 0x0000_1234 to x5, in_valid 3 consecutive cycles -> wb_valid on 3 consecutive cycles, wb_addr=5, wb_data=0x1234, in_ready stays 1.
- LOAD_B addr 0x103, gnt in first REQ cycle, rdata=0x80FF_0000 (rvalid next) -> dmem_addr=0x100, wb_data=0xFFFF_FF80 at T+3; same with LOAD_BU -> 0x0000_0080.
- STORE_H addr 0x202, data 0xDEAD_BEEF, gnt delayed 3 cycles -> req/addr=0x200/wstrb=1100/wdata=0xBEEF_BEEF held all 3 cycles, in_ready=0, wb_valid with wb_en=0 after gnt.
- LOAD_W addr 0x106 -> no dmem_req, misalign_o=1 at T+1, misalign_addr_o=0x106, wb_en=0.
- LOAD_W to x0 returning 0x1234_5678 -> wb_valid=1, wb_en=0.
- Reset asserted in WAIT, then rvalid arrives -> dmem_req=0, no wb_valid, in_ready=1 after reset.
